mult_div_unit: RTL and testbench

- Iterative multiply/divide unit owning the HI/LO registers of the MIPS datapath.
- Sits directly downstream of the register file.
- SrcA/SrcB are driven from the register file read ports (rs/rt).
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Hi/Lo outputs feed the writeback mux for MFHI/MFLO.
- Control stalls dependent instructions while Busy=1.

---
 rtl/mult_div_unit.sv | 117 +++++++++++
 tb/tb_mult_div_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO registers.
// Signed operations run on magnitudes; the latched signs are applied in FIX.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             WriteHi,
   input  logic             WriteLo,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   magA, magB;
   logic               negQ, negR, isDiv, divZero;

   logic               signA, signB;
   logic [WIDTH-1:0]   absA, absB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH-1:0]   divRem;
   logic               divFits;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   quoFix, remFix;

   assign signA = Op[0] & SrcA[WIDTH-1];
   assign signB = Op[0] & SrcB[WIDTH-1];
   assign absA  = signA ? -SrcA : SrcA;
   assign absB  = signB ? -SrcB : SrcB;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);

   // Divide: acc = {remainder, dividend/quotient}; shifted remainder needs one extra bit.
   assign divShift = acc[2*WIDTH-1:WIDTH-1];
   assign divFits  = (divShift >= {1'b0, magB});
   assign divRem   = divShift[WIDTH-1:0] - magB;

   assign prodFix = negQ ? -acc : acc;
   // A zero divisor leaves |A| in the remainder, so re-signing it restores the original SrcA.
   assign quoFix  = divZero ? '1 : (negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
   assign remFix  = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         count   <= '0;
         acc     <= '0;
         magA    <= '0;
         magB    <= '0;
         negQ    <= 1'b0;
         negR    <= 1'b0;
         isDiv   <= 1'b0;
         divZero <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Hi      <= '0;
         Lo      <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  magA    <= absA;
                  magB    <= absB;
                  negQ    <= signA ^ signB;
                  negR    <= signA;
                  isDiv   <= Op[1];
                  divZero <= (SrcB == '0);
                  count   <= '0;
                  acc     <= Op[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                  Busy    <= 1'b1;
                  state   <= Op[1] ? DIV : MUL;
               end else begin
                  if (WriteHi) Hi <= SrcA;
                  if (WriteLo) Lo <= SrcA;
               end
            end
            MUL: begin
               acc   <= {mulSum, acc[WIDTH-1:1]};
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) state <= FIX;
            end
            DIV: begin
               acc   <= {divFits ? divRem : divShift[WIDTH-1:0], acc[WIDTH-2:0], divFits};
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               if (isDiv) begin
                  Hi <= remFix;
                  Lo <= quoFix;
               end else begin
                  Hi <= prodFix[2*WIDTH-1:WIDTH];
                  Lo <= prodFix[WIDTH-1:0];
               end
               Busy  <= 1'b0;
               Done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops against a
// behavioural model, and hand-written sequences for ignore/abort/move cases.
module tb_mult_div_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         Reset, Start, WriteHi, WriteLo;
   logic [1:0]   Op;
   logic [W-1:0] SrcA, SrcB;
   logic         Busy, Done;
   logic [W-1:0] Hi, Lo;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .Reset(Reset), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
      .WriteHi(WriteHi), .WriteLo(WriteLo), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      bit          wrLo;
   } vec_t;

   typedef struct {
      logic [31:0] hi, lo;
   } exp_t;

   exp_t scoreQ[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      longint      sa, sbv;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         2'b00: p = {32'b0, a} * {32'b0, b};
         2'b01: p = sa * sbv;
         2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sbv), 32'(sa / sbv)};
      endcase
      e.hi = p[63:32];
      e.lo = p[31:0];
      return e;
   endfunction

   // One operation: issue at a negedge, follow it cycle by cycle until Done.
   // injCycle > 0 pulses Start(DIVU)+WriteHi mid-operation, which must be ignored.
   task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                        input bit wrLo, input int injCycle);
      exp_t        e, got;
      logic [31:0] hi0, lo0, doneHi, doneLo;
      int          cyc, busyCnt, doneCyc;
      bit          seenDone, holdOk, busyAtDone;
      e.hi = eHi;
      e.lo = eLo;
      scoreQ.push_back(e);
      @(negedge clk);
      hi0 = Hi; lo0 = Lo;
      Start = 1'b1; Op = op; SrcA = a; SrcB = b; WriteLo = wrLo; WriteHi = 1'b0;
      @(negedge clk);
      Start = 1'b0; WriteLo = 1'b0; SrcA = $urandom; SrcB = $urandom;
      cyc = 0; busyCnt = 0; doneCyc = -1; seenDone = 0; holdOk = 1; busyAtDone = 0;
      doneHi = '0; doneLo = '0;
      while (cyc <= 60 && !seenDone) begin
         if (Done) begin
            seenDone = 1; doneCyc = cyc; doneHi = Hi; doneLo = Lo; busyAtDone = Busy;
         end else begin
            if (Busy) busyCnt++;
            if (Hi !== hi0 || Lo !== lo0) holdOk = 0;
            if (cyc == injCycle && injCycle > 0) begin
               Start = 1'b1; Op = 2'b10; WriteHi = 1'b1; SrcA = 32'h5555_5555; SrcB = 32'd3;
            end else begin
               Start = 1'b0; WriteHi = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      Start = 1'b0; WriteHi = 1'b0;
      check({name, "_done_seen"}, 64'(seenDone), 64'd1);
      if (seenDone) begin
         got = scoreQ.pop_front();
         check({name, "_latency"}, 64'(doneCyc), 64'd33);
         check({name, "_busy_cycles"}, 64'(busyCnt), 64'd33);
         check({name, "_busy_at_done"}, 64'(busyAtDone), 64'd0);
         check({name, "_hi"}, 64'(doneHi), 64'(got.hi));
         check({name, "_lo"}, 64'(doneLo), 64'(got.lo));
         check({name, "_hold"}, 64'(holdOk), 64'd1);
         @(negedge clk);
         check({name, "_done_pulse"}, 64'(Done), 64'd0);
      end else begin
         void'(scoreQ.pop_front());
      end
   endtask

   vec_t vt[$];

   initial begin
      exp_t        e;
      logic [31:0] a, b, hiSave, loSave;
      logic [1:0]  op;
      int          doneCnt;

      vt = '{
         '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
         '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0},
         '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0},
         '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
         '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b1},
         '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0},
         '{2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0},
         '{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0},
         '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0},
         '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0},
         '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0},
         '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0}
      };

      Reset = 1'b0; Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
      Op = 2'b00; SrcA = '0; SrcB = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(Busy), 64'd0);
      check("reset_done", 64'(Done), 64'd0);
      check("reset_hi", 64'(Hi), 64'd0);
      check("reset_lo", 64'(Lo), 64'd0);
      Reset = 1'b1;

      foreach (vt[i])
         runOp($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].wrLo, 0);

      e = model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
      runOp("inject", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, e.hi, e.lo, 1'b0, 10);

      for (int i = 0; i < 6; i++) begin
         op = 2'(i % 4);
         a  = $urandom;
         b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         e  = model(op, a, b);
         runOp($sformatf("rand%0d", i), op, a, b, e.hi, e.lo, 1'b0, 0);
      end

      // Moves in IDLE
      @(negedge clk);
      loSave = Lo;
      WriteHi = 1'b1; SrcA = 32'hDEAD_BEEF;
      @(negedge clk);
      WriteHi = 1'b0;
      check("mthi_hi", 64'(Hi), 64'hDEAD_BEEF);
      check("mthi_lo", 64'(Lo), 64'(loSave));
      check("mthi_done", 64'(Done), 64'd0);
      hiSave = Hi;
      WriteLo = 1'b1; SrcA = 32'hCAFE_F00D;
      @(negedge clk);
      WriteLo = 1'b0;
      check("mtlo_lo", 64'(Lo), 64'hCAFE_F00D);
      check("mtlo_hi", 64'(Hi), 64'(hiSave));
      WriteHi = 1'b1; WriteLo = 1'b1; SrcA = 32'h0BAD_CAFE;
      @(negedge clk);
      WriteHi = 1'b0; WriteLo = 1'b0;
      check("mtboth_hi", 64'(Hi), 64'h0BAD_CAFE);
      check("mtboth_lo", 64'(Lo), 64'h0BAD_CAFE);
      check("mtboth_done", 64'(Done), 64'd0);

      // Reset in the middle of a multiply aborts without a Done pulse
      Start = 1'b1; Op = 2'b00; SrcA = 32'hFFFF_FFFF; SrcB = 32'd3;
      @(negedge clk);
      Start = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_busy_before", 64'(Busy), 64'd1);
      Reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(Busy), 64'd0);
      check("abort_hi", 64'(Hi), 64'd0);
      check("abort_lo", 64'(Lo), 64'd0);
      Reset = 1'b1;
      doneCnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (Done) doneCnt++;
      end
      check("abort_no_done", 64'(doneCnt), 64'd0);
      check("abort_idle_busy", 64'(Busy), 64'd0);
      check("abort_idle_hi", 64'(Hi), 64'd0);
      check("scoreboard_empty", 64'(scoreQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
